// File: rtl/eth_types_pkg.sv
// eth_types_pkg: shared Ethernet tx-path types and default timing constants
package eth_types_pkg;
  localparam int ETH_IFG_CYCLES = 48;
  localparam int ETH_MAX_FRAME_BYTES = 1514;
  typedef enum logic [1:0] {TXA_IDLE, TXA_SEND, TXA_DRAIN, TXA_GAP} tx_arb_state;
endpackage

// File: rtl/eth_rr_pick.sv
// eth_rr_pick: one-hot round-robin select of the first requester at or after i_ptr
module eth_rr_pick #(
  parameter int NUM_SRC = 2,
  localparam int PW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_SRC-1:0] o_gnt
);
  logic [2*NUM_SRC-1:0] w_rot;
  logic [2*NUM_SRC-1:0] w_back;
  logic [NUM_SRC-1:0]   w_low;
  logic [NUM_SRC-1:0]   w_off;
  // rotate so i_ptr sits at bit 0, keep lowest set bit, rotate back
  always_comb begin
    w_rot  = {i_req, i_req} >> i_ptr;
    w_low  = w_rot[NUM_SRC-1:0];
    w_off  = w_low & (~w_low + NUM_SRC'(1));
    w_back = {w_off, w_off} << i_ptr;
    o_gnt  = w_back[2*NUM_SRC-1:NUM_SRC];
  end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-atomic round-robin sharing of the MAC tx byte path with IFG and length cap
module eth_tx_arbiter
  import eth_types_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int IFG_CYCLES      = ETH_IFG_CYCLES,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [8*NUM_SRC-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]   i_src_valid,
  input  logic [NUM_SRC-1:0]   i_src_last,
  output logic [NUM_SRC-1:0]   o_src_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_tx_last,
  input  logic                 i_tx_ready,
  output logic [NUM_SRC-1:0]   o_grant,
  output logic                 o_err_truncated
);
  localparam int PW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  tx_arb_state        r_state;
  logic [NUM_SRC-1:0] r_grant;
  logic [PW-1:0]      r_rr_ptr;
  logic [BW-1:0]      r_byte_cnt;
  logic [GW-1:0]      r_gap_cnt;
  logic               r_err;
  logic [NUM_SRC-1:0] w_pick;
  logic [PW-1:0]      w_gidx;
  logic [PW-1:0]      w_next_ptr;
  logic [7:0]         w_data;
  logic               w_vld, w_last, w_send, w_drain, w_cap, w_xfer;
  eth_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .i_req(i_src_valid),
    .i_ptr(r_rr_ptr),
    .o_gnt(w_pick)
  );
  always_comb begin
    w_gidx = '0;
    w_data = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (r_grant[k]) begin
        w_gidx = PW'(k);
        w_data = i_src_data[8*k +: 8];
      end
    w_vld      = |(i_src_valid & r_grant);
    w_last     = |(i_src_last & r_grant);
    w_send     = r_state == TXA_SEND;
    w_drain    = r_state == TXA_DRAIN;
    w_cap      = r_byte_cnt == BW'(MAX_FRAME_BYTES - 1);
    w_next_ptr = (w_gidx == PW'(NUM_SRC - 1)) ? '0 : w_gidx + PW'(1);
    w_xfer     = w_vld & ((w_send & i_tx_ready) | w_drain);
  end
  assign o_tx_data       = w_data;
  assign o_tx_valid      = w_send & w_vld;
  assign o_tx_last       = w_send & w_vld & (w_last | w_cap);
  assign o_src_ready     = ((w_send & i_tx_ready) | w_drain) ? r_grant : '0;
  assign o_grant         = r_grant;
  assign o_err_truncated = r_err;
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= TXA_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        TXA_IDLE:
          if (|i_src_valid) begin
            r_grant <= w_pick;
            r_state <= TXA_SEND;
          end
        TXA_SEND:
          if (w_xfer) begin
            if (w_last) begin
              r_state    <= TXA_GAP;
              r_grant    <= '0;
              r_rr_ptr   <= w_next_ptr;
              r_byte_cnt <= '0;
            end else if (w_cap) begin
              r_state    <= TXA_DRAIN;
              r_err      <= 1'b1;
              r_byte_cnt <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + BW'(1);
            end
          end
        TXA_DRAIN:
          if (w_xfer && w_last) begin
            r_state  <= TXA_GAP;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        TXA_GAP:
          if (r_gap_cnt == GW'(IFG_CYCLES - 1)) begin
            r_state   <= TXA_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        default: r_state <= TXA_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed table plus queue-driven frame model for eth_tx_arbiter
module tb_eth_tx_arbiter;
  localparam int N = 2;
  localparam int IFG = 48;
  localparam int MAXB = 16;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] src_data = '0;
  logic [1:0]  src_valid = '0;
  logic [1:0]  src_last = '0;
  logic [1:0]  src_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b0;
  logic [1:0]  grant;
  logic        err;
  int vecs = 0;
  int miss = 0;
  always #5 clk = ~clk;
  eth_tx_arbiter #(.NUM_SRC(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .i_clk(clk),
    .i_resetn(resetn),
    .i_src_data(src_data),
    .i_src_valid(src_valid),
    .i_src_last(src_last),
    .o_src_ready(src_ready),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .o_tx_last(tx_last),
    .i_tx_ready(tx_ready),
    .o_grant(grant),
    .o_err_truncated(err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic       rn;
    logic [1:0] v;
    logic [1:0] l;
    logic       r;
    logic [1:0] g;
    logic       tv;
    logic [1:0] sr;
    logic       tl;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[14];
  logic [8:0] sq[2][$];
  logic [9:0] eq[$];
  int  fl[2][$];
  int  dly[2];
  bit  sof[2];
  int  mptr = 0;
  int  ready_mode = 0;
  int  gap_mode = 0;
  task automatic load();
    int idx[2];
    int p, s, len;
    bit first, found;
    logic [7:0] d;
    idx = '{0, 0};
    p = mptr;
    first = 1;
    s = 0;
    while (idx[0] < fl[0].size() || idx[1] < fl[1].size()) begin
      found = 0;
      for (int k = 0; k < 2; k++) begin
        int c = (p + k) % 2;
        if (!found && idx[c] < fl[c].size() && (!first || dly[c] == 0)) begin
          s = c;
          found = 1;
        end
      end
      if (!found) begin
        first = 0;
        continue;
      end
      len = fl[s][idx[s]];
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom_range(0, 255));
        sq[s].push_back({b == len - 1, d});
        if (b < MAXB) eq.push_back({len > MAXB && b == MAXB - 1, b == len - 1 || b == MAXB - 1, d});
      end
      idx[s]++;
      p = (s + 1) % 2;
      first = 0;
    end
    mptr = p;
    fl[0].delete();
    fl[1].delete();
  endtask
  task automatic run(input int abort_after);
    int cyc = 0, nx = 0, gap_e = 0, tail = 0;
    bit armed = 0, exp_err = 0;
    logic [8:0] h;
    logic [9:0] e;
    load();
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (dly[s] > 0) begin
          dly[s]--;
          src_valid[s] = 1'b0;
          src_last[s] = 1'b0;
        end else if (sq[s].size() > 0) begin
          h = sq[s][0];
          src_valid[s] = sof[s] || gap_mode == 0 || $urandom_range(0, 3) != 0;
          src_data[8*s +: 8] = h[7:0];
          src_last[s] = h[8];
        end else begin
          src_valid[s] = 1'b0;
          src_last[s] = 1'b0;
        end
      end
      tx_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      #1;
      if (armed) gap_e++;
      chk("grant_onehot", 32'($onehot0(grant)), 1);
      chk("ready_owner", 32'(src_ready & ~grant), 0);
      chk("err_pulse", 32'(err), 32'(exp_err));
      exp_err = 0;
      if (armed && grant != 2'b00) begin
        chk("ifg_edges", gap_e, IFG + 1);
        armed = 0;
      end
      if (tx_valid && tx_ready) begin
        nx++;
        if (eq.size() == 0) begin
          vecs++;
          miss++;
          $display("FAIL tx_extra: got byte %0h with no byte expected", tx_data);
        end else begin
          e = eq.pop_front();
          chk("tx_byte", 32'({tx_last, tx_data}), 32'(e[8:0]));
          if (e[9]) exp_err = 1;
        end
      end
      for (int s = 0; s < 2; s++)
        if (src_valid[s] && src_ready[s] && sq[s].size() > 0) begin
          h = sq[s].pop_front();
          sof[s] = h[8];
          if (h[8]) begin
            armed = 1;
            gap_e = -1;
          end
        end
      if (abort_after > 0 && nx == abort_after) begin
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        resetn = 1'b1;
        src_valid = '0;
        break;
      end
      if (sq[0].size() == 0 && sq[1].size() == 0 && eq.size() == 0) tail++;
      if (tail > IFG + 3) break;
      cyc++;
      if (cyc > 20000) begin
        vecs++;
        miss++;
        $display("FAIL run_timeout: %0d bytes still expected", eq.size());
        break;
      end
    end
    sq[0].delete();
    sq[1].delete();
    eq.delete();
    dly = '{0, 0};
    sof = '{1, 1};
    src_valid = '0;
    src_last = '0;
    if (abort_after > 0) mptr = 0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 2'b11, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 8'hA0};
    tbl[5]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 8'hA0};
    tbl[6]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 8'hA0};
    tbl[7]  = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 8'hA0};
    tbl[8]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 8'hA0};
    tbl[12] = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 8'hA0};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00};
    src_data = 16'hB1A0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      resetn = tbl[i].rn;
      src_valid = tbl[i].v;
      src_last = tbl[i].l;
      tx_ready = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].tv));
      chk($sformatf("tbl%0d_src_ready", i), 32'(src_ready), 32'(tbl[i].sr));
      chk($sformatf("tbl%0d_tx_last", i), 32'(tx_last), 32'(tbl[i].tl));
      chk($sformatf("tbl%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_err", i), 32'(err), 0);
    end
    @(negedge clk);
    resetn = 1'b1;
    src_valid = '0;
    mptr = 0;
    sof = '{1, 1};
    dly = '{0, 0};
    fl[0] = '{4, 4};
    fl[1] = '{4, 4};
    run(0);
    fl[1] = '{1};
    fl[0] = '{3};
    dly = '{2, 0};
    run(0);
    ready_mode = 1;
    fl[0] = '{10};
    run(0);
    ready_mode = 0;
    fl[0] = '{20};
    run(0);
    fl[0] = '{4};
    run(0);
    fl[0] = '{10};
    run(5);
    fl[0] = '{4};
    fl[1] = '{4};
    run(0);
    for (int it = 0; it < 10; it++) begin
      ready_mode = 2;
      gap_mode = int'($urandom_range(0, 1));
      for (int s = 0; s < 2; s++) begin
        int nf = int'($urandom_range(0, 3));
        for (int f = 0; f < nf; f++) fl[s].push_back(int'($urandom_range(1, 24)));
      end
      run(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
